// File: rtl/multi_bullet_ctrl.sv
// Bullet/score engine: spawns, moves, hit-tests and retires up to N_TANKS*N_BULLETS bullets per frame.
// Latency: 2*S+2 cycles from an accepted frame_tick to IDLE (1 spawn, S move, S hit, 1 done).
// Backpressure: frame_tick is only taken in IDLE; ticks arriving while busy=1 are dropped, never queued.
// Optional feature macro: FRIENDLY_FIRE_EN (owner tank is also hit-tested; own hits cost a point).
module multi_bullet_ctrl #(
  parameter int N_TANKS      = 2,
  parameter int N_BULLETS    = 4,
  parameter int BULLET_SPEED = 4,
  parameter int TANK_HALF    = 16,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int COOLDOWN     = 15,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 5
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic                                frame_tick,
  input  logic [N_TANKS-1:0]                  fire,
  input  logic [10*N_TANKS-1:0]               tank_x,
  input  logic [10*N_TANKS-1:0]               tank_y,
  input  logic [2*N_TANKS-1:0]                tank_dir,
  input  logic [N_TANKS*N_BULLETS-1:0]        wall_hit,
  output logic [10*N_TANKS*N_BULLETS-1:0]     bullet_x,
  output logic [10*N_TANKS*N_BULLETS-1:0]     bullet_y,
  output logic [N_TANKS*N_BULLETS-1:0]        bullet_act,
  output logic [N_TANKS-1:0]                  tank_hit,
  output logic [SCORE_W*N_TANKS-1:0]          score,
  output logic                                busy,
  output logic                                game_over,
  output logic [1:0]                          winner
);

  localparam int S   = N_TANKS * N_BULLETS;
  localparam int IW  = (S > 1) ? $clog2(S) : 1;
  localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [IW-1:0]        IDX_LAST  = IW'(S - 1);
  localparam logic [CDW-1:0]       CD_RELOAD = CDW'(COOLDOWN);
  localparam logic [SCORE_W-1:0]   SC_WIN    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]   SC_MAX    = '1;
  localparam logic [9:0]           SPAWN_OFS = 10'(TANK_HALF + 1);
  localparam logic signed [10:0]   SPD       = 11'(BULLET_SPEED);
  localparam logic signed [10:0]   HALF      = 11'(TANK_HALF);
  localparam logic signed [10:0]   X_MAX     = 11'(SCREEN_W - 1);
  localparam logic signed [10:0]   Y_MAX     = 11'(SCREEN_H - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SPAWN = 3'd1;
  localparam logic [2:0] ST_MOVE  = 3'd2;
  localparam logic [2:0] ST_HIT   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]         state;
  logic [IW-1:0]      idx;
  logic [9:0]         bx   [S];
  logic [9:0]         by   [S];
  logic [1:0]         bdir [S];
  logic [S-1:0]       act;
  logic [S-1:0]       fresh;      // spawned this frame; skips its first MOVE visit
  logic [CDW-1:0]     cd   [N_TANKS];
  logic [SCORE_W-1:0] sc   [N_TANKS];
  logic [N_TANKS-1:0] hit_lat;

  logic [N_TANKS-1:0]   sp_ok;
  logic [N_BULLETS-1:0] free_v [N_TANKS];
  logic [N_BULLETS-1:0] sp_sel [N_TANKS];
  logic [9:0]           sp_x   [N_TANKS];
  logic [9:0]           sp_y   [N_TANKS];

  logic signed [10:0] nx, ny;
  logic               off_edge;

  logic [1:0]         owner, hit_t;
  logic               hit_any, elig;
  logic signed [10:0] dx, dy;

  // Per tank: lowest free slot (one-hot), spawn eligibility and muzzle position.
  always_comb begin
    for (int i = 0; i < N_TANKS; i++) begin
      free_v[i] = ~act[i*N_BULLETS +: N_BULLETS];
      sp_sel[i] = free_v[i] & (~free_v[i] + N_BULLETS'(1));
      sp_ok[i]  = fire[i] && (cd[i] == '0) && !game_over && (|free_v[i]);
      sp_x[i]   = tank_x[10*i +: 10];
      sp_y[i]   = tank_y[10*i +: 10];
      case (tank_dir[2*i +: 2])
        2'd0:    sp_y[i] = tank_y[10*i +: 10] - SPAWN_OFS;
        2'd1:    sp_x[i] = tank_x[10*i +: 10] + SPAWN_OFS;
        2'd2:    sp_y[i] = tank_y[10*i +: 10] + SPAWN_OFS;
        default: sp_x[i] = tank_x[10*i +: 10] - SPAWN_OFS;
      endcase
    end
  end

  // Next position of the slot under the MOVE pointer, in signed 11 bits so negatives are visible.
  always_comb begin
    nx = $signed({1'b0, bx[idx]});
    ny = $signed({1'b0, by[idx]});
    case (bdir[idx])
      2'd0:    ny = ny - SPD;
      2'd1:    nx = nx + SPD;
      2'd2:    ny = ny + SPD;
      default: nx = nx - SPD;
    endcase
    off_edge = (nx < 11'sd0) || (nx > X_MAX) || (ny < 11'sd0) || (ny > Y_MAX);
  end

  // Hit test of the slot under the HIT pointer against tanks in ascending order; first match wins.
  always_comb begin
    owner   = '0;
    hit_any = 1'b0;
    hit_t   = '0;
    elig    = 1'b0;
    dx      = '0;
    dy      = '0;
    for (int k = 0; k < S; k++) begin
      if (idx == IW'(k)) owner = 2'(k / N_BULLETS);
    end
    for (int t = 0; t < N_TANKS; t++) begin
      dx = $signed({1'b0, bx[idx]}) - $signed({1'b0, tank_x[10*t +: 10]});
      dy = $signed({1'b0, by[idx]}) - $signed({1'b0, tank_y[10*t +: 10]});
      if (dx < 11'sd0) dx = -dx;
      if (dy < 11'sd0) dy = -dy;
`ifdef FRIENDLY_FIRE_EN
      elig = 1'b1;
`else
      elig = (2'(t) != owner);
`endif
      if (!hit_any && act[idx] && elig && (dx <= HALF) && (dy <= HALF)) begin
        hit_any = 1'b1;
        hit_t   = 2'(t);
      end
    end
  end

  // Frame sequencer and all bullet/score state; every slot update happens on one of these edges.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      act       <= '0;
      fresh     <= '0;
      hit_lat   <= '0;
      tank_hit  <= '0;
      game_over <= 1'b0;
      winner    <= '0;
      for (int k = 0; k < S; k++) begin
        bx[k]   <= '0;
        by[k]   <= '0;
        bdir[k] <= '0;
      end
      for (int i = 0; i < N_TANKS; i++) begin
        cd[i] <= '0;
        sc[i] <= '0;
      end
    end else begin
      tank_hit <= '0;
      case (state)
        ST_IDLE: begin
          if (frame_tick) state <= ST_SPAWN;
        end
        ST_SPAWN: begin
          for (int i = 0; i < N_TANKS; i++) begin
            if (sp_ok[i]) begin
              cd[i] <= CD_RELOAD;
              for (int j = 0; j < N_BULLETS; j++) begin
                if (sp_sel[i][j]) begin
                  act[i*N_BULLETS+j]   <= 1'b1;
                  fresh[i*N_BULLETS+j] <= 1'b1;
                  bx[i*N_BULLETS+j]    <= sp_x[i];
                  by[i*N_BULLETS+j]    <= sp_y[i];
                  bdir[i*N_BULLETS+j]  <= tank_dir[2*i +: 2];
                end
              end
            end else if (cd[i] != '0) begin
              cd[i] <= cd[i] - CDW'(1);
            end
          end
          idx   <= '0;
          state <= ST_MOVE;
        end
        ST_MOVE: begin
          if (act[idx]) begin
            if (fresh[idx]) begin
              fresh[idx] <= 1'b0;
            end else if (!game_over) begin
              if (wall_hit[idx] || off_edge) begin
                act[idx] <= 1'b0;
              end else begin
                bx[idx] <= nx[9:0];
                by[idx] <= ny[9:0];
              end
            end
          end
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= ST_HIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_HIT: begin
          if (hit_any) begin
            act[idx] <= 1'b0;
            for (int t = 0; t < N_TANKS; t++) begin
              if (hit_t == 2'(t)) hit_lat[t] <= 1'b1;
              if (owner == 2'(t)) begin
`ifdef FRIENDLY_FIRE_EN
                if (hit_t == owner) begin
                  if (sc[t] != '0) sc[t] <= sc[t] - SCORE_W'(1);
                end else if (sc[t] != SC_MAX) begin
                  sc[t] <= sc[t] + SCORE_W'(1);
                end
`else
                if (sc[t] != SC_MAX) sc[t] <= sc[t] + SCORE_W'(1);
`endif
              end
            end
          end
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          tank_hit <= hit_lat;
          hit_lat  <= '0;
          // Descending scan so the lowest qualifying tank is the one that sticks.
          if (!game_over) begin
            for (int t = N_TANKS - 1; t >= 0; t--) begin
              if (sc[t] >= SC_WIN) begin
                game_over <= 1'b1;
                winner    <= 2'(t);
              end
            end
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flatten slot and score arrays onto the packed output buses.
  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    score    = '0;
    for (int k = 0; k < S; k++) begin
      bullet_x[10*k +: 10] = bx[k];
      bullet_y[10*k +: 10] = by[k];
    end
    for (int t = 0; t < N_TANKS; t++) begin
      score[SCORE_W*t +: SCORE_W] = sc[t];
    end
  end

  assign bullet_act = act;
  assign busy       = (state != ST_IDLE);

endmodule
